// File: rtl/nmr_acq_pkg.sv
// rtl/nmr_acq_pkg.sv - shared state encodings and sample slot width for the NMR acquisition capture
// Contents:
//   SAMPLE_SLOT_W : width of one packed sample slot in a bus word
//   acq_state_t   : one-hot capture FSM states
package nmr_acq_pkg;

  localparam int SAMPLE_SLOT_W = 16;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ARMED  = 5'b00010,
    ST_CAPT   = 5'b00100,
    ST_FLUSH  = 5'b01000,
    ST_WAITLO = 5'b10000
  } acq_state_t;

endpackage

// File: rtl/nmr_sync_fifo.sv
// rtl/nmr_sync_fifo.sv - first-word fall-through synchronous FIFO with occupancy count
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   wr_en, wr_data    write request; accepted when not full or when a read happens in the same cycle
//   rd_en             pop the head word (ignored while empty)
//   rd_data, rd_valid head word (zero while empty) and non-empty flag
//   count             number of stored words, 0..2**AW
module nmr_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int AW     = 6
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DATA_W-1:0] mem [2**AW];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_rd;
  logic              do_wr;

  assign rd_valid = (count != '0);
  assign do_rd    = rd_en & rd_valid;
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign do_wr    = wr_en & ((count != FULL_CNT) | do_rd);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nmr_acq_capture.sv
// rtl/nmr_acq_capture.sv - ADC capture, sample-pair packing and FIFO buffering per acquisition window
// Ports:
//   CLK, RESET                system clock, asynchronous active-high reset
//   ADC_CLK, ADC_DATA         CLK/4 ADC clock and sample, sampled on the ADC_CLK rising edge
//   FSMSTAT, ACQ_WND          scan active and acquisition window from the pulse program
//   SAMPLES_PER_ECHO          per-window sample cap, 0 = unlimited
//   M_DATA, M_VALID, M_READY  packed word stream {newer, older}
//   ECHO_CNT, WORD_CNT        windows completed / words accepted in the current scan
//   OVERFLOW                  sticky word-dropped flag for the current scan
//   BUSY                      FSM not idle
module nmr_acq_capture
  import nmr_acq_pkg::*;
#(
  parameter int ADC_WIDTH     = 16,
  parameter int DATABUS_WIDTH = 32,
  parameter int FIFO_AW       = 6
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ADC_CLK,
  input  logic [ADC_WIDTH-1:0]     ADC_DATA,
  input  logic                     FSMSTAT,
  input  logic                     ACQ_WND,
  input  logic [DATABUS_WIDTH-1:0] SAMPLES_PER_ECHO,
  output logic [DATABUS_WIDTH-1:0] M_DATA,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [DATABUS_WIDTH-1:0] ECHO_CNT,
  output logic [DATABUS_WIDTH-1:0] WORD_CNT,
  output logic                     OVERFLOW,
  output logic                     BUSY
);

  localparam logic [FIFO_AW:0] FIFO_FULL = {1'b1, {FIFO_AW{1'b0}}};

  acq_state_t               state_q, state_d;
  logic                     adc_d;
  logic                     stb;
  logic [SAMPLE_SLOT_W-1:0] adc_ext;
  logic [SAMPLE_SLOT_W-1:0] low_q;
  logic                     pending_q;
  logic [DATABUS_WIDTH-1:0] rem_q;
  logic                     unlim_q;
  logic                     push_vld_q;
  logic [DATABUS_WIDTH-1:0] push_data_q;
  logic [DATABUS_WIDTH-1:0] echo_q;
  logic [DATABUS_WIDTH-1:0] word_q;
  logic                     ovf_q;
  logic [FIFO_AW:0]         fifo_cnt;
  logic                     pop;
  logic                     push_ok;
  logic                     start_scan;
  logic                     arm_capt;
  logic                     take_smp;
  logic                     do_flush;

  assign stb = ADC_CLK & ~adc_d;

  always_comb begin
    adc_ext                = '0;
    adc_ext[ADC_WIDTH-1:0] = ADC_DATA;
  end

  assign pop     = M_VALID & M_READY;
  assign push_ok = push_vld_q & ((fifo_cnt != FIFO_FULL) | pop);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_scan = 1'b0;
    arm_capt   = 1'b0;
    take_smp   = 1'b0;
    do_flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FSMSTAT) begin
          state_d    = ST_ARMED;
          start_scan = 1'b1;
        end
      end
      ST_ARMED: begin
        if (ACQ_WND) begin
          state_d  = ST_CAPT;
          arm_capt = 1'b1;
        end else if (!FSMSTAT) begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPT: begin
        // Window closing wins over a coincident strobe: that sample is discarded.
        if (!ACQ_WND || !FSMSTAT) begin
          state_d = ST_FLUSH;
        end else if (stb) begin
          take_smp = 1'b1;
          if (!unlim_q && rem_q == DATABUS_WIDTH'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        do_flush = 1'b1;
        state_d  = ACQ_WND ? ST_WAITLO : ST_ARMED;
      end
      ST_WAITLO: begin
        if (!ACQ_WND)      state_d = ST_ARMED;
        else if (!FSMSTAT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Completed words go through a one-cycle push register, so the FIFO write
  // lands the cycle after the strobe that completed the pair.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      adc_d       <= 1'b0;
      low_q       <= '0;
      pending_q   <= 1'b0;
      rem_q       <= '0;
      unlim_q     <= 1'b0;
      push_vld_q  <= 1'b0;
      push_data_q <= '0;
      echo_q      <= '0;
      word_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      adc_d      <= ADC_CLK;
      push_vld_q <= 1'b0;

      if (start_scan) begin
        echo_q <= '0;
        word_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok)                 word_q <= word_q + 1'b1;
        if (push_vld_q && !push_ok)  ovf_q  <= 1'b1;
        if (do_flush)                echo_q <= echo_q + 1'b1;
      end

      if (arm_capt) begin
        rem_q   <= SAMPLES_PER_ECHO;
        unlim_q <= (SAMPLES_PER_ECHO == '0);
      end

      if (take_smp) begin
        if (!unlim_q) rem_q <= rem_q - 1'b1;
        if (pending_q) begin
          push_vld_q  <= 1'b1;
          push_data_q <= {adc_ext, low_q};
          pending_q   <= 1'b0;
        end else begin
          low_q     <= adc_ext;
          pending_q <= 1'b1;
        end
      end

      if (do_flush && pending_q) begin
        push_vld_q  <= 1'b1;
        push_data_q <= {{SAMPLE_SLOT_W{1'b0}}, low_q};
        pending_q   <= 1'b0;
      end
    end
  end

  nmr_sync_fifo #(
    .DATA_W (DATABUS_WIDTH),
    .AW     (FIFO_AW)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .wr_en    (push_vld_q),
    .wr_data  (push_data_q),
    .rd_en    (M_READY),
    .rd_data  (M_DATA),
    .rd_valid (M_VALID),
    .count    (fifo_cnt)
  );

  assign ECHO_CNT = echo_q;
  assign WORD_CNT = word_q;
  assign OVERFLOW = ovf_q;
  assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nmr_acq_capture.sv
// tb/tb_nmr_acq_capture.sv - self-checking bench for nmr_acq_capture with an output scoreboard
module tb_nmr_acq_capture;
  import nmr_acq_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ADC_CLK = 1'b0;
  logic [15:0] ADC_DATA = '0;
  logic        FSMSTAT = 1'b0;
  logic        ACQ_WND = 1'b0;
  logic [31:0] SAMPLES_PER_ECHO = '0;
  logic [31:0] M_DATA;
  logic        M_VALID;
  logic        M_READY = 1'b1;
  logic [31:0] ECHO_CNT;
  logic [31:0] WORD_CNT;
  logic        OVERFLOW;
  logic        BUSY;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          model_nw;
  logic        stalled = 1'b0;
  logic [31:0] held = '0;

  nmr_acq_capture #(
    .ADC_WIDTH     (16),
    .DATABUS_WIDTH (32),
    .FIFO_AW       (2)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .ADC_CLK          (ADC_CLK),
    .ADC_DATA         (ADC_DATA),
    .FSMSTAT          (FSMSTAT),
    .ACQ_WND          (ACQ_WND),
    .SAMPLES_PER_ECHO (SAMPLES_PER_ECHO),
    .M_DATA           (M_DATA),
    .M_VALID          (M_VALID),
    .M_READY          (M_READY),
    .ECHO_CNT         (ECHO_CNT),
    .WORD_CNT         (WORD_CNT),
    .OVERFLOW         (OVERFLOW),
    .BUSY             (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: compares every accepted word and checks that a
  // stalled word does not change.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        stalled = 1'b0;
      end else begin
        if (stalled && M_VALID) check("hold_data", M_DATA, held);
        stalled = M_VALID && !M_READY;
        held    = M_DATA;
        if (M_VALID && M_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL spurious_word observed=%0h expected=none", M_DATA);
          end else begin
            check("word", M_DATA, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic adc_sample(input logic [15:0] v, input bit pulse_ready);
    ADC_DATA = v;
    ADC_CLK  = 1'b1;
    step(1);
    if (pulse_ready) M_READY = 1'b1;
    step(1);
    if (pulse_ready) M_READY = 1'b0;
    ADC_CLK = 1'b0;
    step(2);
  endtask

  task automatic queue_word(input logic [31:0] w, input int keep_max);
    if (model_nw < keep_max) exp_q.push_back(w);
    model_nw++;
  endtask

  task automatic start_scan();
    FSMSTAT = 1'b1;
    step(2);
  endtask

  task automatic end_scan();
    FSMSTAT = 1'b0;
    step(3);
  endtask

  task automatic close_window();
    ACQ_WND = 1'b0;
    step(4);
  endtask

  // Opens a window and drives n strobes; the model queues the words the DUT must emit.
  task automatic send_window(input int spe, input int n, input int keep_max, input int pulse_idx);
    logic [15:0] lo, v;
    bit pend;
    bit capped;
    int cap;
    pend     = 1'b0;
    lo       = '0;
    model_nw = 0;
    capped   = (spe != 0) && (n >= spe);
    cap      = capped ? spe : n;
    SAMPLES_PER_ECHO = 32'(spe);
    ACQ_WND = 1'b1;
    step(2);
    for (int i = 0; i < n; i++) begin
      v = 16'($urandom);
      if (i < cap) begin
        if (pend) begin
          queue_word({v, lo}, keep_max);
          pend = 1'b0;
        end else begin
          lo   = v;
          pend = 1'b1;
        end
        if (capped && i == cap - 1 && pend) begin
          queue_word({16'h0, lo}, keep_max);
          pend = 1'b0;
        end
      end
      adc_sample(v, i == pulse_idx);
    end
    if (pend) queue_word({16'h0, lo}, keep_max);
  endtask

  task automatic wait_drain(input string tag);
    int i;
    M_READY = 1'b1;
    i = 0;
    while (i < 300 && (exp_q.size() != 0 || M_VALID)) begin
      step(1);
      i++;
    end
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_low"}, {31'd0, M_VALID}, 32'd0);
  endtask

  initial begin
    step(3);
    check("rst_valid", {31'd0, M_VALID}, 32'd0);
    check("rst_data", M_DATA, 32'd0);
    check("rst_echo", ECHO_CNT, 32'd0);
    check("rst_word", WORD_CNT, 32'd0);
    check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    RESET = 1'b0;
    step(2);

    // 1: cap of 4 inside a 16-strobe window
    start_scan();
    check("t1_busy", {31'd0, BUSY}, 32'd1);
    send_window(4, 16, 1000, -1);
    close_window();
    check("t1_echo", ECHO_CNT, 32'd1);
    check("t1_word", WORD_CNT, 32'd2);
    wait_drain("t1");
    end_scan();
    check("t1_idle", {31'd0, BUSY}, 32'd0);

    // 2: odd cap leaves a zero-padded half word, then waits for the window to fall
    start_scan();
    send_window(3, 6, 1000, -1);
    check("t2_waitlo", 32'(dut.state_q), 32'(ST_WAITLO));
    close_window();
    check("t2_armed", 32'(dut.state_q), 32'(ST_ARMED));
    check("t2_word", WORD_CNT, 32'd2);
    wait_drain("t2");
    end_scan();

    // 3: unlimited windows, three echoes
    start_scan();
    for (int e = 0; e < 3; e++) begin
      send_window(0, 20, 1000, -1);
      close_window();
    end
    check("t3_echo", ECHO_CNT, 32'd3);
    check("t3_word", WORD_CNT, 32'd30);
    check("t3_ovf", {31'd0, OVERFLOW}, 32'd0);
    wait_drain("t3");
    end_scan();

    // 4a: stalled consumer, depth 4, 12 words offered
    M_READY = 1'b0;
    start_scan();
    send_window(0, 24, 4, -1);
    close_window();
    check("t4_ovf", {31'd0, OVERFLOW}, 32'd1);
    check("t4_word", WORD_CNT, 32'd4);
    check("t4_echo", ECHO_CNT, 32'd1);
    wait_drain("t4");
    end_scan();

    // 4b: one pop coincides with the push into a full FIFO
    M_READY = 1'b0;
    start_scan();
    check("t4b_ovf_clr", {31'd0, OVERFLOW}, 32'd0);
    send_window(0, 10, 1000, 9);
    close_window();
    check("t4b_word", WORD_CNT, 32'd5);
    check("t4b_ovf", {31'd0, OVERFLOW}, 32'd0);
    wait_drain("t4b");
    end_scan();

    // 5: consumer ready toggles every cycle
    start_scan();
    fork
      send_window(0, 16, 1000, -1);
      begin
        for (int c = 0; c < 90; c++) begin
          step(1);
          M_READY = ~M_READY;
        end
      end
    join
    close_window();
    check("t5_word", WORD_CNT, 32'd8);
    check("t5_ovf", {31'd0, OVERFLOW}, 32'd0);
    wait_drain("t5");
    end_scan();

    // 6: reset mid-window with a half word pending
    start_scan();
    SAMPLES_PER_ECHO = 32'd4;
    ACQ_WND = 1'b1;
    step(2);
    adc_sample(16'hBEEF, 1'b0);
    RESET = 1'b1;
    #2;
    check("t6_valid", {31'd0, M_VALID}, 32'd0);
    check("t6_data", M_DATA, 32'd0);
    check("t6_echo", ECHO_CNT, 32'd0);
    check("t6_word", WORD_CNT, 32'd0);
    check("t6_ovf", {31'd0, OVERFLOW}, 32'd0);
    check("t6_busy", {31'd0, BUSY}, 32'd0);
    FSMSTAT = 1'b0;
    ACQ_WND = 1'b0;
    step(3);
    RESET = 1'b0;
    step(4);
    check("t6_no_partial", {31'd0, M_VALID}, 32'd0);
    start_scan();
    send_window(2, 2, 1000, -1);
    close_window();
    check("t6_echo2", ECHO_CNT, 32'd1);
    check("t6_word2", WORD_CNT, 32'd1);
    wait_drain("t6");
    end_scan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
